execute_muldiv: RTL and testbench
=================================

// Module: execute_muldiv
// PURPOSE
//  Multicycle multiply/divide unit for the execute stage, successor to the fixed 32-bit mult/multu pair.
//  Width-parametrised; adds DIV/DIVU, HI/LO result registers, a start/busy/done handshake and a divide-by-zero flag.
//  Execute stage issues an op, stalls on busy, then reads hi/lo. ALU ops never enter this block.
// PARAMETERS
//  WIDTH   32  operand width in bits; legal range 4..64. HI and LO are each WIDTH bits wide.
//  DIV_EN  1   1 = DIV/DIVU supported; 0 = div opcodes treated as non-muldiv (ignored).
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        asynchronous, active-high reset
//  start        in   1        issue request; sampled only when busy==0
//  ALU_ctr      in   6        op select: 6'h0e MULT, 6'h16 MULTU, 6'h1a DIV, 6'h1b DIVU
//  busA         in   WIDTH    operand A (multiplicand / dividend)
//  busB         in   WIDTH    operand B (multiplier / divisor)
//  busy         out  1        op in flight; stage must stall
//  done         out  1        one-cycle pulse; hi/lo valid from this cycle
//  div_by_zero  out  1        registered; updated with done, held until next done
//  hi           out  WIDTH    mult: upper product half; div: remainder
//  lo           out  WIDTH    mult: lower product half; div: quotient
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy, done, div_by_zero = 0; hi, lo = 0; any in-flight op discarded.
//  FSM: IDLE -> CALC -> FIX -> IDLE.
//   IDLE: start && valid op at edge 0 -> latch op, |A|, |B| (abs only for signed ops), result signs; count=0; -> CALC.
//   CALC: exactly WIDTH edges. Radix-2 shift-add multiply or restoring divide on unsigned magnitudes,
//         2*WIDTH-bit accumulator. After the WIDTH-th iteration -> FIX.
//   FIX: one edge. Apply sign correction; write hi/lo and div_by_zero; done=1; -> IDLE.
//  Latency: done high in the cycle after edge WIDTH+1 (33 clocks for WIDTH=32). busy high from edge 0
//   through the FIX edge; busy==0 in the done cycle, so back-to-back issue is legal then.
//  start while busy: ignored, no queueing. start with a non-muldiv op: ignored, no done, hi/lo unchanged.
//  Operand/op changes after edge 0 have no effect.
//  Sign rules:
//   MULT: product negated iff sign(A)^sign(B). MULTU: no correction.
//   DIV/DIVU: quotient truncates toward zero; remainder takes the sign of the dividend.
//  MIN/-1 (DIV): lo = MIN, hi = 0, from natural wrap; no special case.
//  Divisor==0 (DIV or DIVU): full latency still taken. lo = all ones, hi = busA as issued, div_by_zero = 1.
//   div_by_zero is cleared by the next completed op with a nonzero divisor, and by any mult.
//  hi/lo change only on the FIX edge or on reset.
// STRUCTURE
//  Package muldiv_pkg: opcode localparams (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), FSM state encoding,
//   and an is_muldiv_op(ALU_ctr, DIV_EN) function.
//  Sub-module twos_abs #(WIDTH): conditional negate (in, neg_en -> out). Used twice for operand magnitudes
//   and twice (HI, LO) for result correction.
//  Everything else is inline: FSM, iteration counter ($clog2(WIDTH+1) bits), accumulator, divisor/multiplicand registers.
// TESTING (WIDTH=32 unless noted)
//  MULTU 7*6 -> done at clock 33; lo=42, hi=0. MULT -1*-1 -> hi=0, lo=1.
//  MULTU ffffffff*ffffffff -> hi=fffffffe, lo=00000001. MULT 80000000*80000000 -> hi=40000000, lo=0.
//  DIV -7/2 -> lo=fffffffd, hi=ffffffff. DIV 80000000/ffffffff -> lo=80000000, hi=0.
//   DIVU 100/7 -> lo=14, hi=2.
//  DIVU 5/0 -> lo=ffffffff, hi=5, div_by_zero=1; next MULTU 1*1 -> div_by_zero=0.
//  Second start 3 cycles after issue with different operands -> ignored; first result intact, exactly one done.
//   Back-to-back issue in the done cycle -> accepted.
//  Assert reset at CALC cycle 10 -> busy, done, hi, lo = 0 immediately; next op completes normally.
//   Also run WIDTH=8 with DIV_EN=0: DIV opcode ignored; MULT -128*-128 -> hi=40, lo=00.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM encoding and op decode for the execute-stage multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned OP_W = 6;

   localparam logic [OP_W-1:0] OP_MULT  = 6'h0e;
   localparam logic [OP_W-1:0] OP_MULTU = 6'h16;
   localparam logic [OP_W-1:0] OP_DIV   = 6'h1a;
   localparam logic [OP_W-1:0] OP_DIVU  = 6'h1b;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   function automatic logic is_muldiv_op(input logic [OP_W-1:0] alu_ctr, input logic div_en);
      return (alu_ctr == OP_MULT) || (alu_ctr == OP_MULTU) ||
             (div_en && ((alu_ctr == OP_DIV) || (alu_ctr == OP_DIVU)));
   endfunction

endpackage

// File: rtl/twos_abs.sv
// Conditional two's-complement negate: magnitude extraction and result sign correction.
module twos_abs #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] in,
   input  logic             neg_en,
   output logic [WIDTH-1:0] out
);

   assign out = neg_en ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/execute_muldiv.sv
// Multicycle multiply/divide unit: shift-add multiply and restoring divide on magnitudes,
// one sign-fix cycle, results held in hi/lo.
module execute_muldiv
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter bit          DIV_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       ALU_ctr,
   input  logic [WIDTH-1:0] busA,
   input  logic [WIDTH-1:0] busB,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [1:0]         state, state_next;
   logic [CW-1:0]      count;
   logic               is_div, zero_div, neg_lo, neg_hi;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;

   logic               accept_c, signed_op_c, div_op_c, sign_a_c, sign_b_c, b_zero_c;
   logic [WIDTH-1:0]   abs_a_c, abs_b_c, hi_in_c, hi_fix_c, lo_fix_c;
   logic [WIDTH:0]     mul_sum_c, div_rem_c, div_diff_c;
   logic [2*WIDTH-1:0] step_c;

   // Issue decode: signs are only meaningful for the signed opcodes.
   assign signed_op_c = (ALU_ctr == OP_MULT) || (ALU_ctr == OP_DIV);
   assign div_op_c    = (ALU_ctr == OP_DIV) || (ALU_ctr == OP_DIVU);
   assign sign_a_c    = signed_op_c && busA[WIDTH-1];
   assign sign_b_c    = signed_op_c && busB[WIDTH-1];
   assign b_zero_c    = (busB == '0);
   assign accept_c    = (state == S_IDLE) && start && is_muldiv_op(ALU_ctr, DIV_EN);

   twos_abs #(.WIDTH(WIDTH)) u_abs_a (.in(busA), .neg_en(sign_a_c), .out(abs_a_c));
   twos_abs #(.WIDTH(WIDTH)) u_abs_b (.in(busB), .neg_en(sign_b_c), .out(abs_b_c));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (accept_c) state_next = S_CALC;
         S_CALC:  if (count == CW'(WIDTH - 1)) state_next = S_FIX;
         S_FIX:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // One iteration: add-and-shift-right for multiply, shift-left-and-trial-subtract for divide.
   always_comb begin
      mul_sum_c  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
      div_rem_c  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff_c = div_rem_c - {1'b0, mcand};
      if (is_div)
         step_c = div_diff_c[WIDTH] ? {div_rem_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         step_c = {mul_sum_c, acc[WIDTH-1:1]};
   end

   // Negating a 2W product: hi becomes ~hi unless lo is zero, i.e. -(hi+1) when lo != 0.
   assign hi_in_c = acc[2*WIDTH-1:WIDTH] + WIDTH'(!is_div && neg_lo && (|acc[WIDTH-1:0]));

   twos_abs #(.WIDTH(WIDTH)) u_fix_hi (.in(hi_in_c), .neg_en(neg_hi), .out(hi_fix_c));
   twos_abs #(.WIDTH(WIDTH)) u_fix_lo (.in(acc[WIDTH-1:0]), .neg_en(neg_lo), .out(lo_fix_c));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         count       <= '0;
         is_div      <= 1'b0;
         zero_div    <= 1'b0;
         neg_lo      <= 1'b0;
         neg_hi      <= 1'b0;
         mcand       <= '0;
         acc         <= '0;
      end else begin
         done <= 1'b0;
         busy <= (state_next != S_IDLE);
         case (state)
            S_IDLE: if (accept_c) begin
               count    <= '0;
               is_div   <= div_op_c;
               zero_div <= div_op_c && b_zero_c;
               // A zero divisor leaves the all-ones quotient uncorrected.
               neg_lo   <= (sign_a_c ^ sign_b_c) && !(div_op_c && b_zero_c);
               neg_hi   <= div_op_c ? sign_a_c : (sign_a_c ^ sign_b_c);
               mcand    <= div_op_c ? abs_b_c : abs_a_c;
               acc      <= {WIDTH'(0), (div_op_c ? abs_a_c : abs_b_c)};
            end
            S_CALC: begin
               acc   <= step_c;
               count <= count + CW'(1);
            end
            S_FIX: begin
               hi          <= hi_fix_c;
               lo          <= lo_fix_c;
               div_by_zero <= zero_div;
               done        <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench: directed table, random ops against an arithmetic model,
// handshake corner cases, and an 8-bit multiply-only instance.
module tb_execute_muldiv;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, start8;
   logic [5:0]  ALU_ctr, ctr8;
   logic [31:0] busA, busB, hi, lo;
   logic [7:0]  a8, b8, hi8, lo8;
   logic        busy, done, div_by_zero, busy8, done8, dbz8;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   execute_muldiv #(.WIDTH(32), .DIV_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .ALU_ctr(ALU_ctr), .busA(busA), .busB(busB),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo));

   execute_muldiv #(.WIDTH(8), .DIV_EN(1'b0)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .ALU_ctr(ctr8), .busA(a8), .busB(b8),
      .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8));

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a, b, hi, lo;
      logic        dbz;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: full-width signed/unsigned arithmetic, SV division truncates toward zero.
   function automatic void model32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] mh, output logic [31:0] ml, output logic mz);
      longint     sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      mz = 1'b0;
      mh = '0;
      ml = '0;
      case (op)
         OP_MULT:  begin p = 64'(sa * sb); mh = p[63:32]; ml = p[31:0]; end
         OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; mh = p[63:32]; ml = p[31:0]; end
         OP_DIV: if (b == 0) begin mh = a; ml = '1; mz = 1'b1; end
                 else begin ml = 32'(sa / sb); mh = 32'(sa % sb); end
         OP_DIVU: if (b == 0) begin mh = a; ml = '1; mz = 1'b1; end
                  else begin ml = a / b; mh = a % b; end
         default: ;
      endcase
   endfunction

   // Issue at the current (negedge) time, scramble inputs after edge 0, wait for done.
   task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl, output logic rz,
                         output int lat);
      start = 1'b1; ALU_ctr = op; busA = a; busB = b;
      @(posedge clk); #1;
      start = 1'b0; ALU_ctr = 6'($urandom); busA = $urandom; busB = $urandom;
      lat = 0;
      while (lat < 100) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (lat == 1) check("busy_in_flight", busy, 1);
         if (done) break;
      end
      check("done_seen", done, 1);
      check("busy_at_done", busy, 0);
      rh = hi; rl = lo; rz = div_by_zero;
   endtask

   task automatic run8(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] rh, output logic [7:0] rl, output int lat);
      start8 = 1'b1; ctr8 = op; a8 = a; b8 = b;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 0;
      while (lat < 30) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (done8) break;
      end
      rh = hi8; rl = lo8;
   endtask

   vec_t        tbl[12];
   logic [31:0] rh, rl, mh, ml;
   logic        rz, mz;
   logic [7:0]  rh8, rl8;
   int          lat, ndone, nbusy;

   initial begin
      tbl[0]  = '{OP_MULTU, 32'd7,          32'd6,          32'h0,        32'd42,       1'b0};
      tbl[1]  = '{OP_MULT,  32'hffffffff,   32'hffffffff,   32'h0,        32'h1,        1'b0};
      tbl[2]  = '{OP_MULTU, 32'hffffffff,   32'hffffffff,   32'hfffffffe, 32'h00000001, 1'b0};
      tbl[3]  = '{OP_MULT,  32'h80000000,   32'h80000000,   32'h40000000, 32'h0,        1'b0};
      tbl[4]  = '{OP_DIV,   32'hfffffff9,   32'd2,          32'hffffffff, 32'hfffffffd, 1'b0};
      tbl[5]  = '{OP_DIV,   32'h80000000,   32'hffffffff,   32'h0,        32'h80000000, 1'b0};
      tbl[6]  = '{OP_DIVU,  32'd100,        32'd7,          32'd2,        32'd14,       1'b0};
      tbl[7]  = '{OP_DIVU,  32'd5,          32'd0,          32'd5,        32'hffffffff, 1'b1};
      tbl[8]  = '{OP_MULTU, 32'd1,          32'd1,          32'h0,        32'h1,        1'b0};
      tbl[9]  = '{OP_DIV,   32'd7,          32'hfffffffe,   32'd1,        32'hfffffffd, 1'b0};
      tbl[10] = '{OP_DIV,   32'hfffffff9,   32'd0,          32'hfffffff9, 32'hffffffff, 1'b1};
      tbl[11] = '{OP_MULT,  32'hfffffffd,   32'd7,          32'hffffffff, 32'hffffffeb, 1'b0};

      reset = 1'b1; start = 1'b0; ALU_ctr = '0; busA = '0; busB = '0;
      start8 = 1'b0; ctr8 = '0; a8 = '0; b8 = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_dbz", div_by_zero, 0);
      check("reset_hi", hi, 0);
      check("reset_lo", lo, 0);
      reset = 1'b0;
      @(negedge clk);

      // Directed table; each op issues in the done cycle of the previous one.
      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, rh, rl, rz, lat);
         check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd33);
         check($sformatf("tbl%0d_hi", i), rh, tbl[i].hi);
         check($sformatf("tbl%0d_lo", i), rl, tbl[i].lo);
         check($sformatf("tbl%0d_dbz", i), rz, tbl[i].dbz);
      end

      // Random ops against the arithmetic model.
      for (int i = 0; i < 60; i++) begin
         logic [5:0]  op;
         logic [31:0] a, b;
         int          r;
         case ($urandom_range(0, 3))
            0:       op = OP_MULT;
            1:       op = OP_MULTU;
            2:       op = OP_DIV;
            default: op = OP_DIVU;
         endcase
         a = $urandom;
         if ($urandom_range(0, 9) == 0) a = 32'h80000000;
         r = $urandom_range(0, 7);
         b = (r == 0) ? 32'h0 : (r == 1) ? 32'($urandom_range(1, 15)) :
             (r == 2) ? 32'hffffffff : 32'($urandom);
         model32(op, a, b, mh, ml, mz);
         run_op(op, a, b, rh, rl, rz, lat);
         check($sformatf("rnd%0d_op%h_%h_%h_hi", i, op, a, b), rh, mh);
         check($sformatf("rnd%0d_op%h_%h_%h_lo", i, op, a, b), rl, ml);
         check($sformatf("rnd%0d_dbz", i), rz, mz);
      end

      // Second start while busy must be dropped.
      start = 1'b1; ALU_ctr = OP_MULTU; busA = 32'd3; busB = 32'd5;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; ALU_ctr = OP_DIVU; busA = 32'd100; busB = 32'd7;
      @(negedge clk); start = 1'b0;
      ndone = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            rh = hi; rl = lo;
         end
      end
      check("busy_ignore_ndone", 64'(ndone), 64'd1);
      check("busy_ignore_hi", rh, 32'd0);
      check("busy_ignore_lo", rl, 32'd15);

      // Non-muldiv opcode: no busy, no done, results untouched.
      start = 1'b1; ALU_ctr = 6'h20; busA = 32'd9; busB = 32'd9;
      @(negedge clk); start = 1'b0;
      ndone = 0; nbusy = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) ndone++;
         if (busy) nbusy++;
      end
      check("nonop_ndone", 64'(ndone), 64'd0);
      check("nonop_nbusy", 64'(nbusy), 64'd0);
      check("nonop_hi", hi, 32'd0);
      check("nonop_lo", lo, 32'd15);

      // Async reset during CALC, then a clean op.
      start = 1'b1; ALU_ctr = OP_DIVU; busA = 32'd9; busB = 32'd0;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      check("busy_before_reset", busy, 1);
      reset = 1'b1;
      #1;
      check("midreset_busy", busy, 0);
      check("midreset_done", done, 0);
      check("midreset_hi", hi, 0);
      check("midreset_lo", lo, 0);
      check("midreset_dbz", div_by_zero, 0);
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      run_op(OP_MULTU, 32'd9, 32'd9, rh, rl, rz, lat);
      check("post_reset_latency", 64'(lat), 64'd33);
      check("post_reset_lo", rl, 32'd81);
      check("post_reset_hi", rh, 32'd0);

      // WIDTH=8, DIV_EN=0.
      start8 = 1'b1; ctr8 = OP_DIV; a8 = 8'd20; b8 = 8'd3;
      @(negedge clk); start8 = 1'b0;
      ndone = 0; nbusy = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done8) ndone++;
         if (busy8) nbusy++;
      end
      check("w8_div_ignored_ndone", 64'(ndone), 64'd0);
      check("w8_div_ignored_nbusy", 64'(nbusy), 64'd0);
      run8(OP_MULT, 8'h80, 8'h80, rh8, rl8, lat);
      check("w8_mult_latency", 64'(lat), 64'd9);
      check("w8_mult_hi", rh8, 8'h40);
      check("w8_mult_lo", rl8, 8'h00);
      run8(OP_MULTU, 8'hff, 8'hff, rh8, rl8, lat);
      check("w8_multu_hi", rh8, 8'hfe);
      check("w8_multu_lo", rl8, 8'h01);
      run8(OP_MULT, 8'hfd, 8'h07, rh8, rl8, lat);
      check("w8_mult_neg_hi", rh8, 8'hff);
      check("w8_mult_neg_lo", rl8, 8'heb);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
